regfile_bypass: RTL

- 32-entry ARM register file: two combinational read ports and one synchronous write port.
- Sits in the decode stage. Fed by the writeback stage; feeds the ID/EX pipeline registers.
- Each entry is a bank of enabled D flip-flops.
- Internal write-to-read bypass lets an instruction in decode see a value being written back in the same cycle, so no stall is needed.
- Entry 31 is the hardwired zero register (XZR).

---
 rtl/regfile_bypass.sv | 69 ++++++
 1 files changed

// File: rtl/regfile_bypass.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, same-cycle write-to-read bypass, and a hardwired-zero entry.

module regfile_entry #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);
  localparam logic [4:0] ZR = ZERO_REG[4:0];

  logic [NREGS-1:0][WIDTH-1:0] q;
  logic [NREGS-1:0]            wen;

  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    if (i == ZERO_REG) begin : g_zero
      assign wen[i] = 1'b0;
      assign q[i]   = '0;
    end else begin : g_reg
      // one-hot decode of the write index, qualified by the write strobe
      assign wen[i] = RegWrite && (WriteRegister == 5'(i));
      regfile_entry #(.WIDTH(WIDTH)) u_ent (
        .clk  (clk),
        .reset(reset),
        .en   (wen[i]),
        .d    (WriteData),
        .q    (q[i])
      );
    end
  end

  // Bypass is suppressed in reset: a write presented then is never committed.
  logic byp1, byp2;
  assign byp1 = RegWrite && !reset && (WriteRegister == ReadRegister1);
  assign byp2 = RegWrite && !reset && (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = q[ReadRegister1];
    if (byp1)                ReadData1 = WriteData;
    if (ReadRegister1 == ZR) ReadData1 = '0;
    ReadData2 = q[ReadRegister2];
    if (byp2)                ReadData2 = WriteData;
    if (ReadRegister2 == ZR) ReadData2 = '0;
  end
endmodule
